mul_2nbit_booth: RTL and testbench
==================================

Name: mul_2nbit_booth

Overview:
- Sequential radix-2 Booth multiplier for two signed (two's-complement) DATA_WIDTH-bit operands.
- Produces a signed 2*DATA_WIDTH-bit product after DATA_WIDTH iterations, one iteration per clock.
- Operands are captured while reset is asserted; computation starts when reset is released.
- Used as a standalone arithmetic unit in the calc/mul group; no handshake other than a done flag.

Parameters:
- DATA_WIDTH, 4, operand width N (N >= 2); product width is 2N.

Ports:
- i_clk  input  1  clock, all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset; also acts as load/start.
- i_num_x  input  DATA_WIDTH  multiplicand X, signed.
- i_num_y  input  DATA_WIDTH  multiplier Y, signed.
- o_end  output  1  high when the product is valid; held until the next reset.
- o_res  output  2*DATA_WIDTH  signed product X*Y; 0 while not done.
- o_cry  output  1  carry-out of the final iteration's N-bit add/sub; 0 while not done.

Behaviour:
- Internal registers:
  - Xr (N bits): latched X.
  - A (N+1 bits): signed accumulator, with one extra bit so that X = -2^(N-1) does not overflow.
  - Q (N bits): multiplier and low product.
  - q1 (1 bit): Booth history bit.
  - cnt: ceil(log2(N+1)) bits.
  - cry (1 bit).
  - state: RUN or DONE.
- Reset (i_rst=1 at a rising edge):
  - Xr=i_num_x, A=0, Q=i_num_y, q1=0, cnt=0, cry=0, state=RUN.
  - Outputs go to o_end=0, o_res=0, o_cry=0.
  - Reset in the middle of an operation aborts it and reloads the operands.
- RUN, each clock with i_rst=0, selects on {Q[0],q1}:
  - 00 or 11: no add; cry=0.
  - 01: A = A + sext(Xr); cry = carry-out of A[N-1:0] + Xr.
  - 10: A = A + sext(~Xr) + 1; cry = carry-out of A[N-1:0] + ~Xr + 1.
  - Then shift {A,Q,q1} arithmetic-right by 1 (A MSB replicated). cnt increments.
  - When cnt reaches N-1 in this cycle (the N-th iteration), state becomes DONE.
- DONE:
  - All registers are held.
  - o_end=1, o_res={A[N-1:0],Q}, o_cry=cry.
  - Stays in DONE until the next reset. Input changes are ignored.
- Latency: the product is valid at the N-th rising edge after the first edge with i_rst=0. For N=4 that is 4 cycles.
- Outputs are combinational decodes of the registers, gated by state==DONE.
- The result is exact for all input pairs, including (-2^(N-1)) * (-2^(N-1)) = +2^(2N-2).
- Operand changes during RUN have no effect, because the operands are latched at reset.

Test Plan:
- X=4'b1010 (-6), Y=4'b1001 (-7); reset 1 cycle then release -> o_end=0 for cycles 1-3, rises on the 4th edge; o_res=8'h2A (42), o_cry=1; holds for 10 cycles.
- X=4'b1010 (-6), Y=4'b0101 (5); reset then release -> after 4 cycles o_end=1, o_res=8'hE2 (-30), o_cry=0.
- X=4'b0111, Y=4'b0111 -> o_res=8'h31 (49), o_cry=1.
- X=4'b1000, Y=4'b1000 -> o_res=8'h40 (+64), o_cry=0; checks the corner case where Xr = -2^(N-1).
- Reset asserted after 2 run cycles with new operands X=4'b0011, Y=4'b1110:
  - during reset: o_end=0, o_res=0;
  - 4 cycles after release: o_res=8'hFA (-6).
- Exhaustive check of all 256 pairs for N=4 -> o_res equals the signed product and o_end asserts exactly 4 cycles after reset release.

Source files
------------

// File: rtl/mul_2nbit_booth.sv
// Sequential radix-2 Booth multiplier: signed N x N -> signed 2N product.
// Operands are captured while i_rst is high; one Booth step per clock after
// release, and the product is valid after N steps until the next reset.
//
// state | meaning
// RUN   | iterating; cnt holds the number of completed Booth steps
// DONE  | product valid in {A[N-1:0],Q}; all registers frozen
module mul_2nbit_booth #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DATA_WIDTH-1:0]   i_num_x,
  input  logic [DATA_WIDTH-1:0]   i_num_y,
  output logic                    o_end,
  output logic [2*DATA_WIDTH-1:0] o_res,
  output logic                    o_cry
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  x_q;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic          q1_q, q1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cry_q, cry_d;

  logic          add_en;
  logic          sub;
  logic [N-1:0]  addend_lo;
  logic          addend_hi;
  logic [N:0]    sum_lo;
  logic [N:0]    a_sum;

  // Add/sub datapath: the low N bits give the reported carry; the extra top
  // bit of A is completed by a single full-adder bit on the sign extension.
  always_comb begin
    add_en    = q_q[0] ^ q1_q;
    sub       = q_q[0];
    addend_lo = sub ? ~x_q : x_q;
    addend_hi = sub ? ~x_q[N-1] : x_q[N-1];
    sum_lo    = {1'b0, a_q[N-1:0]} + {1'b0, addend_lo} + {{N{1'b0}}, sub};
    a_sum     = {a_q[N] ^ addend_hi ^ sum_lo[N], sum_lo[N-1:0]};
  end

  // Next-state: one Booth step plus arithmetic right shift per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    cry_d   = cry_q;
    case (state_q)
      RUN: begin
        if (add_en) begin
          {a_d, q_d, q1_d} = {a_sum[N], a_sum, q_q};
          cry_d            = sum_lo[N];
        end else begin
          {a_d, q_d, q1_d} = {a_q[N], a_q, q_q};
          cry_d            = 1'b0;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = DONE;
      end
    endcase
  end

  // Register update; reset doubles as operand load and start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      x_q     <= i_num_x;
      a_q     <= '0;
      q_q     <= i_num_y;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      cry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      cry_q   <= cry_d;
    end
  end

  // Outputs are visible only once the product is complete.
  always_comb begin
    o_end = (state_q == DONE);
    o_res = o_end ? {a_q[N-1:0], q_q} : '0;
    o_cry = o_end ? cry_q : 1'b0;
  end

endmodule

// File: tb/tb_mul_2nbit_booth.sv
// Scoreboard bench for mul_2nbit_booth (N=4): directed cases, abort on
// reset, hold after done, and all 256 operand pairs.
module tb_mul_2nbit_booth;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [3:0] i_num_x = '0;
  logic [3:0] i_num_y = '0;
  logic       o_end;
  logic [7:0] o_res;
  logic       o_cry;

  typedef struct {
    logic [7:0] res;
    logic       cry;
    bit         chk_cry;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mul_2nbit_booth #(.DATA_WIDTH(4)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_num_x (i_num_x),
    .i_num_y (i_num_y),
    .o_end   (o_end),
    .o_res   (o_res),
    .o_cry   (o_cry)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Load operands under reset; optionally push the expected result.
  task automatic start_op(input logic [3:0] x, input logic [3:0] y, input bit push,
                          input bit chk_cry, input logic cry);
    exp_t e;
    logic signed [3:0] xs;
    logic signed [3:0] ys;
    int p;
    @(negedge i_clk);
    i_rst   = 1'b1;
    i_num_x = x;
    i_num_y = y;
    @(negedge i_clk);
    chk("rst_end", 16'(o_end), 16'd0);
    chk("rst_res", 16'(o_res), 16'd0);
    chk("rst_cry", 16'(o_cry), 16'd0);
    if (push) begin
      xs = x;
      ys = y;
      p  = int'(xs) * int'(ys);
      e.res     = p[7:0];
      e.cry     = cry;
      e.chk_cry = chk_cry;
      sb_q.push_back(e);
    end
    i_rst = 1'b0;
  endtask

  // Wait (bounded) for o_end, scrambling operands meanwhile, then compare.
  task automatic wait_result(input string tag, output exp_t e);
    int cyc;
    cyc = 0;
    e.res = '0; e.cry = 1'b0; e.chk_cry = 1'b0;
    while (cyc < 20) begin
      @(negedge i_clk);
      cyc++;
      if (o_end) break;
      chk({tag, "_busy_res"}, 16'(o_res), 16'd0);
      chk({tag, "_busy_cry"}, 16'(o_cry), 16'd0);
      i_num_x = 4'($urandom);
      i_num_y = 4'($urandom);
    end
    chk({tag, "_latency"}, 16'(cyc), 16'd4);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_res"}, 16'(o_res), 16'(e.res));
      if (e.chk_cry) chk({tag, "_cry"}, 16'(o_cry), 16'(e.cry));
    end
  endtask

  task automatic hold_check(input int n, input exp_t e);
    for (int i = 0; i < n; i++) begin
      i_num_x = 4'($urandom);
      i_num_y = 4'($urandom);
      @(negedge i_clk);
      chk("hold_end", 16'(o_end), 16'd1);
      chk("hold_res", 16'(o_res), 16'(e.res));
      chk("hold_cry", 16'(o_cry), 16'(e.cry));
    end
  endtask

  initial begin
    exp_t e;
    @(negedge i_clk);
    chk("init_end", 16'(o_end), 16'd0);
    chk("init_res", 16'(o_res), 16'd0);
    chk("init_cry", 16'(o_cry), 16'd0);

    start_op(4'b1010, 4'b1001, 1'b1, 1'b1, 1'b1);
    wait_result("m6xm7", e);
    chk("m6xm7_const", 16'(o_res), 16'h2A);
    hold_check(10, e);

    start_op(4'b1010, 4'b0101, 1'b1, 1'b1, 1'b0);
    wait_result("m6x5", e);
    chk("m6x5_const", 16'(o_res), 16'hE2);

    start_op(4'b0111, 4'b0111, 1'b1, 1'b1, 1'b1);
    wait_result("7x7", e);
    chk("7x7_const", 16'(o_res), 16'h31);

    start_op(4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0);
    wait_result("m8xm8", e);
    chk("m8xm8_const", 16'(o_res), 16'h40);

    start_op(4'b1010, 4'b1001, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("abort_mid_end", 16'(o_end), 16'd0);
    start_op(4'b0011, 4'b1110, 1'b1, 1'b0, 1'b0);
    wait_result("abort", e);
    chk("abort_const", 16'(o_res), 16'hFA);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        start_op(4'(x), 4'(y), 1'b1, 1'b0, 1'b0);
        wait_result("exh", e);
      end
    end

    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
